// File: rtl/rect_flip_engine.sv
// Rectangle-flip engine: loads a ROWS x COLS bit matrix, XOR-flips the four
// corners of each legal rectangle command (one per cycle), then presents the result.
module rect_flip_engine #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int RW   = (ROWS > 2) ? $clog2(ROWS) : 1,
   parameter int CW   = (COLS > 2) ? $clog2(COLS) : 1,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [ROWS*COLS-1:0] load_data,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [RW-1:0]        cmd_r1,
   input  logic [RW-1:0]        cmd_r2,
   input  logic [CW-1:0]        cmd_c1,
   input  logic [CW-1:0]        cmd_c2,
   input  logic                 cmd_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ROWS*COLS-1:0] m_out,
   output logic [CNTW-1:0]      flip_count,
   output logic [1:0]           err
);

   localparam int N = ROWS * COLS;
   localparam logic [RW:0]    ROWS_L = (RW+1)'(ROWS);
   localparam logic [CW:0]    COLS_L = (CW+1)'(COLS);
   localparam logic [31:0]    COLS_U = 32'(COLS);
   localparam logic [N-1:0]   ONE    = {{(N-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] INC   = {{(CNTW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   logic [N-1:0]    r_m;
   logic [CNTW-1:0] r_cnt;
   logic [1:0]      r_err;
   logic            r_load_ready;
   logic            r_cmd_ready;
   logic            r_out_valid;

   logic            w_oor;
   logic            w_degen;
   logic [31:0]     w_i11, w_i12, w_i21, w_i22;
   logic [N-1:0]    w_mask;

   // Corner bits are ORed one-hot terms; out-of-range shifts fall off the top
   // but those commands are never applied anyway.
   always_comb begin
      w_oor   = ({1'b0, cmd_r1} >= ROWS_L) || ({1'b0, cmd_r2} >= ROWS_L) ||
                ({1'b0, cmd_c1} >= COLS_L) || ({1'b0, cmd_c2} >= COLS_L);
      w_degen = (cmd_r1 == cmd_r2) || (cmd_c1 == cmd_c2);
      w_i11   = 32'(cmd_r1) * COLS_U + 32'(cmd_c1);
      w_i12   = 32'(cmd_r1) * COLS_U + 32'(cmd_c2);
      w_i21   = 32'(cmd_r2) * COLS_U + 32'(cmd_c1);
      w_i22   = 32'(cmd_r2) * COLS_U + 32'(cmd_c2);
      w_mask  = (ONE << w_i11) | (ONE << w_i12) | (ONE << w_i21) | (ONE << w_i22);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_m          <= '0;
         r_cnt        <= '0;
         r_err        <= '0;
         r_load_ready <= 1'b1;
         r_cmd_ready  <= 1'b0;
         r_out_valid  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (load_valid) begin
               r_m          <= load_data;
               r_cnt        <= '0;
               r_err        <= '0;
               r_load_ready <= 1'b0;
               r_cmd_ready  <= 1'b1;
               r_state      <= S_RUN;
            end
            S_RUN: if (cmd_valid) begin
               if (w_oor || w_degen) begin
                  r_err <= r_err | {w_degen, w_oor};
               end else begin
                  r_m <= r_m ^ w_mask;
                  if (r_cnt != '1) r_cnt <= r_cnt + INC;
               end
               if (cmd_last) begin
                  r_cmd_ready <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: if (out_ready) begin
               r_out_valid  <= 1'b0;
               r_load_ready <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state      <= S_IDLE;
               r_load_ready <= 1'b1;
               r_cmd_ready  <= 1'b0;
               r_out_valid  <= 1'b0;
            end
         endcase
      end
   end

   assign load_ready = r_load_ready;
   assign cmd_ready  = r_cmd_ready;
   assign out_valid  = r_out_valid;
   assign m_out      = r_m;
   assign flip_count = r_cnt;
   assign err        = r_err;

endmodule

// File: tb/tb_rect_flip_engine.sv
// Directed bench for rect_flip_engine: a 4x4 instance and a 3x5 instance with a
// 2-bit counter to reach the range and saturation corners.
module tb_rect_flip_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   // 4x4 instance
   logic        load_valid, load_ready, cmd_valid, cmd_ready, cmd_last;
   logic        out_valid, out_ready;
   logic [15:0] load_data, m_out;
   logic [1:0]  cmd_r1, cmd_r2, cmd_c1, cmd_c2, err;
   logic [15:0] flip_count;

   rect_flip_engine #(.ROWS(4), .COLS(4), .CNTW(16)) u_dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_r1(cmd_r1), .cmd_r2(cmd_r2), .cmd_c1(cmd_c1), .cmd_c2(cmd_c2),
      .cmd_last(cmd_last), .out_valid(out_valid), .out_ready(out_ready),
      .m_out(m_out), .flip_count(flip_count), .err(err)
   );

   // 3x5 instance, CNTW=2
   logic        b_load_valid, b_load_ready, b_cmd_valid, b_cmd_ready, b_cmd_last;
   logic        b_out_valid, b_out_ready;
   logic [14:0] b_load_data, b_m_out;
   logic [1:0]  b_r1, b_r2, b_err, b_flip_count;
   logic [2:0]  b_c1, b_c2;

   rect_flip_engine #(.ROWS(3), .COLS(5), .CNTW(2)) u_dut35 (
      .clk(clk), .rst(rst),
      .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_r1(b_r1), .cmd_r2(b_r2), .cmd_c1(b_c1), .cmd_c2(b_c2),
      .cmd_last(b_cmd_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .m_out(b_m_out), .flip_count(b_flip_count), .err(b_err)
   );

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_cmd(input logic v, input logic [1:0] r1, input logic [1:0] r2,
                          input logic [1:0] c1, input logic [1:0] c2, input logic last);
      cmd_valid = v; cmd_r1 = r1; cmd_r2 = r2; cmd_c1 = c1; cmd_c2 = c2; cmd_last = last;
   endtask

   task automatic set_bcmd(input logic v, input logic [1:0] r1, input logic [1:0] r2,
                           input logic [2:0] c1, input logic [2:0] c2, input logic last);
      b_cmd_valid = v; b_r1 = r1; b_r2 = r2; b_c1 = c1; b_c2 = c2; b_cmd_last = last;
   endtask

   task automatic load4(input logic [15:0] d);
      load_valid = 1'b1; load_data = d;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      n_checks++;
      if (m_out !== 16'h0 || flip_count !== 16'h0 || err !== 2'b00 || out_valid !== 1'b0 ||
          cmd_ready !== 1'b0 || load_ready !== 1'b1) begin
         n_errs++;
         $display("FAIL reset: m=%h cnt=%0d err=%b ov=%b cr=%b lr=%b want 0 0 00 0 0 1",
                  m_out, flip_count, err, out_valid, cmd_ready, load_ready);
      end
      n_checks++;
      if (b_m_out !== 15'h0 || b_flip_count !== 2'd0 || b_load_ready !== 1'b1) begin
         n_errs++;
         $display("FAIL reset35: m=%h cnt=%0d lr=%b want 0 0 1", b_m_out, b_flip_count, b_load_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      load4(16'h0000);
      n_checks++;
      if (cmd_ready !== 1'b1 || load_ready !== 1'b0) begin
         n_errs++;
         $display("FAIL basic_run: cr=%b lr=%b want 1 0", cmd_ready, load_ready);
      end
      set_cmd(1'b1, 2'd0, 2'd1, 2'd0, 2'd1, 1'b1);
      tick();
      set_cmd(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      n_checks++;
      if (m_out !== 16'h0033 || flip_count !== 16'd1 || err !== 2'b00 || out_valid !== 1'b1) begin
         n_errs++;
         $display("FAIL basic_result: m=%h cnt=%0d err=%b ov=%b want 0033 1 00 1",
                  m_out, flip_count, err, out_valid);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_errs++;
         $display("FAIL basic_release: lr=%b ov=%b want 1 0", load_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      load4(16'hFFFF);
      set_cmd(1'b1, 2'd0, 2'd1, 2'd0, 2'd1, 1'b0);
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_errs++; $display("FAIL b2b_ready1: cr=%b want 1", cmd_ready);
      end
      tick();
      n_checks++;
      if (cmd_ready !== 1'b1 || m_out !== 16'hFFCC || flip_count !== 16'd1) begin
         n_errs++;
         $display("FAIL b2b_mid: cr=%b m=%h cnt=%0d want 1 ffcc 1", cmd_ready, m_out, flip_count);
      end
      cmd_last = 1'b1;
      tick();
      set_cmd(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      n_checks++;
      if (m_out !== 16'hFFFF || flip_count !== 16'd2 || out_valid !== 1'b1) begin
         n_errs++;
         $display("FAIL b2b_result: m=%h cnt=%0d ov=%b want ffff 2 1", m_out, flip_count, out_valid);
      end
   endtask

   // Runs straight after test_back_to_back, which leaves the engine in DONE.
   task automatic test_backpressure();
      set_cmd(1'b1, 2'd0, 2'd1, 2'd0, 2'd1, 1'b1);
      load_valid = 1'b1; load_data = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || m_out !== 16'hFFFF || flip_count !== 16'd2 ||
             cmd_ready !== 1'b0 || load_ready !== 1'b0) begin
            n_errs++;
            $display("FAIL hold_%0d: ov=%b m=%h cnt=%0d cr=%b lr=%b want 1 ffff 2 0 0",
                     i, out_valid, m_out, flip_count, cmd_ready, load_ready);
         end
      end
      set_cmd(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      load_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (load_ready !== 1'b1 || out_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         n_errs++;
         $display("FAIL hold_release: lr=%b ov=%b cr=%b want 1 0 0", load_ready, out_valid, cmd_ready);
      end
   endtask

   task automatic test_degenerate();
      load4(16'h1234);
      set_cmd(1'b1, 2'd2, 2'd2, 2'd0, 2'd3, 1'b0);
      tick();
      n_checks++;
      if (err !== 2'b10 || flip_count !== 16'd0 || m_out !== 16'h1234) begin
         n_errs++;
         $display("FAIL degen_reject: err=%b cnt=%0d m=%h want 10 0 1234", err, flip_count, m_out);
      end
      set_cmd(1'b1, 2'd0, 2'd3, 2'd0, 2'd3, 1'b1);
      tick();
      set_cmd(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      n_checks++;
      if (err !== 2'b10 || flip_count !== 16'd1 || m_out !== 16'h823D || out_valid !== 1'b1) begin
         n_errs++;
         $display("FAIL degen_then_legal: err=%b cnt=%0d m=%h ov=%b want 10 1 823d 1",
                  err, flip_count, m_out, out_valid);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_out_of_range();
      b_load_valid = 1'b1; b_load_data = 15'h5A5A;
      tick();
      b_load_valid = 1'b0;
      set_bcmd(1'b1, 2'd3, 2'd0, 3'd0, 3'd1, 1'b1);
      tick();
      set_bcmd(1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
      n_checks++;
      if (b_err !== 2'b01 || b_m_out !== 15'h5A5A || b_flip_count !== 2'd0 || b_out_valid !== 1'b1) begin
         n_errs++;
         $display("FAIL oor_row: err=%b m=%h cnt=%0d ov=%b want 01 5a5a 0 1",
                  b_err, b_m_out, b_flip_count, b_out_valid);
      end
      b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
      // Both faults: rows out of range and equal, columns equal.
      b_load_valid = 1'b1; b_load_data = 15'h0001;
      tick();
      b_load_valid = 1'b0;
      set_bcmd(1'b1, 2'd3, 2'd3, 3'd1, 3'd1, 1'b0);
      tick();
      n_checks++;
      if (b_err !== 2'b11 || b_m_out !== 15'h0001) begin
         n_errs++;
         $display("FAIL both_faults: err=%b m=%h want 11 0001", b_err, b_m_out);
      end
      // Column out of range only (c2=5 >= COLS).
      set_bcmd(1'b1, 2'd0, 2'd1, 3'd0, 3'd5, 1'b1);
      tick();
      set_bcmd(1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
      n_checks++;
      if (b_err !== 2'b11 || b_m_out !== 15'h0001 || b_flip_count !== 2'd0) begin
         n_errs++;
         $display("FAIL oor_col: err=%b m=%h cnt=%0d want 11 0001 0", b_err, b_m_out, b_flip_count);
      end
      b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
   endtask

   task automatic test_saturation();
      b_load_valid = 1'b1; b_load_data = 15'h0000;
      tick();
      b_load_valid = 1'b0;
      set_bcmd(1'b1, 2'd0, 2'd1, 3'd0, 3'd1, 1'b0); tick();
      set_bcmd(1'b1, 2'd1, 2'd2, 3'd0, 3'd1, 1'b0); tick();
      set_bcmd(1'b1, 2'd0, 2'd2, 3'd3, 3'd4, 1'b0); tick();
      n_checks++;
      if (b_flip_count !== 2'd3 || b_err !== 2'b00) begin
         n_errs++;
         $display("FAIL sat_three: cnt=%0d err=%b want 3 00", b_flip_count, b_err);
      end
      set_bcmd(1'b1, 2'd0, 2'd1, 3'd0, 3'd1, 1'b1); tick();
      set_bcmd(1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
      n_checks++;
      if (b_flip_count !== 2'd3 || b_m_out !== 15'h6C78) begin
         n_errs++;
         $display("FAIL sat_hold: cnt=%0d m=%h want 3 6c78", b_flip_count, b_m_out);
      end
      b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
   endtask

   task automatic test_mid_run_reset();
      load4(16'h0F0F);
      set_cmd(1'b1, 2'd0, 2'd1, 2'd0, 2'd1, 1'b0); tick();
      set_cmd(1'b1, 2'd1, 2'd2, 2'd1, 2'd2, 1'b0); tick();
      set_cmd(1'b1, 2'd3, 2'd3, 2'd0, 2'd1, 1'b0); tick();
      set_cmd(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (m_out !== 16'h0 || flip_count !== 16'd0 || err !== 2'b00 || load_ready !== 1'b1 ||
          cmd_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_errs++;
         $display("FAIL midrun_reset: m=%h cnt=%0d err=%b lr=%b cr=%b ov=%b want 0 0 00 1 0 0",
                  m_out, flip_count, err, load_ready, cmd_ready, out_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      load_valid = 1'b0; load_data = '0; out_ready = 1'b0;
      set_cmd(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      b_load_valid = 1'b0; b_load_data = '0; b_out_ready = 1'b0;
      set_bcmd(1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_degenerate();
      test_out_of_range();
      test_saturation();
      test_mid_run_reset();
      test_basic();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
